// File: rtl/if_prefetch_unit.sv
// Instruction-fetch unit: issues single-beat Wishbone reads ahead of decode
// and buffers the returned words in a small prefetch FIFO. A redirect flushes
// the FIFO and restarts fetch; any read still in flight is drained and dropped.
module if_prefetch_unit #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
  output logic                    inst_valid_o,
  output logic [DATA_WIDTH-1:0]   inst_o,
  output logic [ADDR_WIDTH-1:0]   inst_pc_o,
  output logic                    inst_err_o,
  input  logic                    inst_ready_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic                  err;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

  state_t                state;
  logic                  req;
  logic [ADDR_WIDTH-1:0] adr;
  logic [ADDR_WIDTH-1:0] fetch_pc;

  entry_t                mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;

  logic                  term, push, pop, slot_free;
  logic [PW:0]           cnt_after;
  entry_t                push_ent, head;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc_i[1:0];
  assign redir_pc         = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  // Handshake decode: termination of the outstanding read, FIFO push/pop and
  // whether a slot remains free once this cycle's push/pop has happened.
  always_comb begin
    term      = req & (wb_ack_i | wb_err_i);
    push      = (state == REQ) & term & ~redirect_valid_i;
    pop       = inst_valid_o & inst_ready_i & ~redirect_valid_i;
    cnt_after = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    slot_free = cnt_after < DEPTH_C;
    push_ent  = '0;
    push_ent.pc = adr;
    if (wb_err_i) push_ent.err = 1'b1;
    else          push_ent.data = wb_dat_i;
  end

  // Prefetch FIFO storage; a redirect empties it and wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (redirect_valid_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_after;
    end
  end

  // Fetch FSM: owns the bus request registers and the next fetch address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      adr      <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid_i) begin
      fetch_pc <= redir_pc;
      if (req && !term) begin
        state <= DRAIN;            // keep cyc/stb/adr until the slave answers
      end else begin
        state <= IDLE;
        req   <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: if (slot_free) begin
          req   <= 1'b1;
          adr   <= fetch_pc;
          state <= REQ;
        end
        REQ: if (wb_err_i) begin
          req   <= 1'b0;
          state <= HALT;
        end else if (wb_ack_i) begin
          fetch_pc <= adr + ADDR_WIDTH'(4);
          if (slot_free) begin
            adr <= adr + ADDR_WIDTH'(4);   // back-to-back, no idle cycle
          end else begin
            req   <= 1'b0;
            state <= IDLE;
          end
        end
        DRAIN: if (term) begin
          req   <= 1'b0;
          state <= IDLE;
        end
        default: ;                 // HALT: wait for a redirect
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? head.data : '0;
  assign inst_pc_o    = inst_valid_o ? head.pc   : '0;
  assign inst_err_o   = inst_valid_o & head.err;

  assign wb_cyc_o = req;
  assign wb_stb_o = req;
  assign wb_adr_o = adr;
  assign wb_sel_o = {(DATA_WIDTH/8){req}};
  assign wb_dat_o = '0;
  assign wb_we_o  = 1'b0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: Wishbone slave with programmable wait states and
// error address, an instruction-stream reference model, and directed steps
// followed by a randomized phase.
module tb_if_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_err, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        wb_cyc, wb_stb, wb_ack, wb_err, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  int          n_asrt = 0;
  int          n_fail = 0;
  int          wait_states = 0;
  logic [31:0] err_adr = 32'h1;
  int          wcnt = 0;
  int          push_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_req = RPC;
  logic        drain = 1'b0;
  logic        halted = 1'b0;
  logic        mon_term;

  if_prefetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_err_o(inst_err), .inst_ready_i(inst_ready),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel), .wb_we_o(wb_we)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Slave: decides termination for the coming edge, counting wait states.
  always @(negedge clk) begin
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = 32'hDEAD_BEEF;
    if (wb_cyc && wb_stb) begin
      if (wcnt >= wait_states) begin
        if (wb_adr == err_adr) wb_err = 1'b1;
        else begin
          wb_ack   = 1'b1;
          wb_dat_i = mf(wb_adr);
        end
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  // Reference model: expected fetch address stream and FIFO contents.
  always @(negedge clk) begin
    #3;
    if (!reset_n) begin
      q.delete();
      exp_req = RPC;
      drain   = 1'b0;
      halted  = 1'b0;
    end else begin
      mon_term = wb_cyc && (wb_ack || wb_err);
      chk("valid_vs_model", 32'(inst_valid), 32'(q.size() != 0));
      chk("occupancy_bound", 32'((q.size() + 32'(wb_cyc)) <= DEPTH), 32'd1);
      if (halted) chk("halt_no_cyc", 32'(wb_cyc), 32'd0);
      if (q.size() != 0) begin
        chk("head_pc", inst_pc, q[0].pc);
        chk("head_data", inst, q[0].data);
        chk("head_err", 32'(inst_err), 32'(q[0].err));
      end
      if (redirect_valid) begin
        drain   = wb_cyc && !mon_term;
        q.delete();
        exp_req = {redirect_pc[31:2], 2'b00};
        halted  = 1'b0;
      end else begin
        if (inst_valid && inst_ready && q.size() != 0) void'(q.pop_front());
        if (mon_term) begin
          if (drain) drain = 1'b0;
          else begin
            chk("req_adr", wb_adr, exp_req);
            q.push_back('{pc: exp_req, data: wb_err ? 32'h0 : mf(exp_req), err: wb_err});
            exp_req = exp_req + 32'd4;
            push_cnt++;
            if (wb_err) halted = 1'b1;
          end
        end
      end
    end
  end

  // Directed steps, then randomized traffic.
  initial begin
    int  base;
    bit  found;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    tick(3);
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_sel", 32'(wb_sel), 0);
    chk("rst_adr", wb_adr, RPC);
    chk("rst_dat_o", wb_dat_o, 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_err", 32'(inst_err), 0);

    // Reset fetch with zero-wait slave
    reset_n = 1'b1;
    tick();
    chk("rf_cyc0", 32'(wb_cyc), 1);
    chk("rf_adr0", wb_adr, RPC);
    chk("rf_valid0", 32'(inst_valid), 0);
    tick();
    chk("rf_adr1", wb_adr, RPC + 4);
    chk("rf_pc0", inst_pc, RPC);
    chk("rf_inst0", inst, mf(RPC));
    tick();
    chk("rf_adr2", wb_adr, RPC + 8);
    chk("rf_pc1", inst_pc, RPC + 4);
    chk("rf_cyc2", 32'(wb_cyc), 1);

    // Back-pressure
    inst_ready = 1'b0;
    redir(RPC);
    base = push_cnt;
    tick(6);
    chk("bp_cyc", 32'(wb_cyc), 0);
    chk("bp_valid", 32'(inst_valid), 1);
    chk("bp_head", inst_pc, RPC);
    tick(3);
    chk("bp_acks", 32'(push_cnt - base), 4);
    inst_ready = 1'b1;
    tick();
    chk("bp_resume_adr", wb_adr, RPC + 32'h10);
    chk("bp_resume_cyc", 32'(wb_cyc), 1);
    chk("bp_pop_next", inst_pc, RPC + 4);

    // Redirect while idle with a full FIFO
    inst_ready = 1'b0;
    tick(8);
    chk("ri_full_cyc", 32'(wb_cyc), 0);
    redir(32'h0000_1002);
    chk("ri_flushed", 32'(inst_valid), 0);
    tick();
    chk("ri_cyc", 32'(wb_cyc), 1);
    chk("ri_adr", wb_adr, 32'h0000_1000);

    // Redirect with a read in flight
    wait_states = 3;
    inst_ready  = 1'b1;
    redir(32'h0000_3000);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (wb_cyc && wb_adr == 32'h0000_3000) found = 1;
      else tick();
    end
    chk("rf_inflight_seen", 32'(found), 1);
    tick();
    redir(32'h0000_2000);
    chk("rf_drain_cyc", 32'(wb_cyc), 1);
    chk("rf_drain_adr", wb_adr, 32'h0000_3000);
    chk("rf_drain_valid", 32'(inst_valid), 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (inst_valid) found = 1;
    end
    chk("rf_new_seen", 32'(found), 1);
    chk("rf_new_pc", inst_pc, 32'h0000_2000);
    chk("rf_new_inst", inst, mf(32'h0000_2000));

    // Bus error
    wait_states = 0;
    err_adr     = RPC + 8;
    redir(RPC);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (inst_valid && inst_err) found = 1;
    end
    chk("be_seen", 32'(found), 1);
    chk("be_pc", inst_pc, RPC + 8);
    chk("be_inst", inst, 0);
    tick(4);
    chk("be_halt_cyc", 32'(wb_cyc), 0);
    chk("be_halt_valid", 32'(inst_valid), 0);
    err_adr = 32'h1;
    redir(RPC + 32'h100);
    tick();
    chk("be_resume_cyc", 32'(wb_cyc), 1);
    chk("be_resume_adr", wb_adr, RPC + 32'h100);

    // Address wrap
    redir(32'hFFFF_FFF8);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (inst_valid && inst_pc == 32'h0) found = 1;
    end
    chk("wrap_seen", 32'(found), 1);
    chk("wrap_inst", inst, mf(32'h0));

    // Reset during a wait state
    wait_states = 3;
    redir(32'h0000_4000);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (wb_cyc && wb_adr == 32'h0000_4000) found = 1;
      else tick();
    end
    chk("rm_inflight_seen", 32'(found), 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rm_cyc", 32'(wb_cyc), 0);
    chk("rm_stb", 32'(wb_stb), 0);
    chk("rm_valid", 32'(inst_valid), 0);
    tick(2);
    reset_n = 1'b1;
    tick();
    chk("rm_cyc_after", 32'(wb_cyc), 1);
    chk("rm_adr_after", wb_adr, RPC);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) wait_states = $urandom_range(0, 2);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_pc    = (i % 3 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      redirect_valid = ($urandom_range(0, 39) == 0);
      tick();
    end
    redirect_valid = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
